// File: rtl/player_ctrl.sv
// Per-player motion/animation controller: turns joystick and collision levels
// into a frame-synchronous sprite position and sprite index.
module player_ctrl #(
  parameter int START_X     = 32,
  parameter int START_Y     = 32,
  parameter int SPEED       = 2,
  parameter int X_MIN       = 32,
  parameter int X_MAX       = 576,
  parameter int Y_MIN       = 32,
  parameter int Y_MAX       = 416,
  parameter int ANIM_DIV    = 8,
  parameter int DEAD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       blk_up,
  input  logic       blk_down,
  input  logic       blk_left,
  input  logic       blk_right,
  input  logic       kill,
  output logic [9:0] playerX,
  output logic [9:0] playerY,
  output logic [2:0] sprite_num,
  output logic       alive
);

  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int DW = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;

  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_FRAMES - 1);

  localparam logic signed [10:0] SPD   = 11'(SPEED);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {IDLE, WALK, DEAD} state_t;

  state_t        state;
  logic [1:0]    dir;
  logic [AW-1:0] anim_cnt;
  logic          phase;
  logic [DW-1:0] dead_cnt;

  logic                req_valid;
  logic [1:0]          req_dir;
  logic                req_blk;
  logic signed [10:0]  cand_x;
  logic signed [10:0]  cand_y;
  logic [9:0]          new_x;
  logic [9:0]          new_y;
  logic                anim_wrap;
  logic                next_phase;

  // Single-direction request, priority up > down > left > right.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_DOWN;
    req_blk   = 1'b0;
    if (btn_up) begin
      req_dir = DIR_UP;
      req_blk = blk_up;
    end else if (btn_down) begin
      req_dir = DIR_DOWN;
      req_blk = blk_down;
    end else if (btn_left) begin
      req_dir = DIR_LEFT;
      req_blk = blk_left;
    end else if (btn_right) begin
      req_dir = DIR_RIGHT;
      req_blk = blk_right;
    end else begin
      req_valid = 1'b0;
    end
  end

  // Candidate move at 11 bits signed, then saturated into the clamp window.
  always_comb begin
    cand_x = $signed({1'b0, playerX});
    cand_y = $signed({1'b0, playerY});
    if (!req_blk) begin
      case (req_dir)
        DIR_UP:    cand_y = $signed({1'b0, playerY}) - SPD;
        DIR_DOWN:  cand_y = $signed({1'b0, playerY}) + SPD;
        DIR_LEFT:  cand_x = $signed({1'b0, playerX}) - SPD;
        default:   cand_x = $signed({1'b0, playerX}) + SPD;
      endcase
    end
    if (cand_x < XMIN_S)      new_x = XMIN_S[9:0];
    else if (cand_x > XMAX_S) new_x = XMAX_S[9:0];
    else                      new_x = cand_x[9:0];
    if (cand_y < YMIN_S)      new_y = YMIN_S[9:0];
    else if (cand_y > YMAX_S) new_y = YMAX_S[9:0];
    else                      new_y = cand_y[9:0];
  end

  // Counter and phase are always zero in IDLE, so the first walking tick counts too.
  always_comb begin
    anim_wrap  = (anim_cnt == ANIM_LAST);
    next_phase = phase ^ anim_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= DIR_DOWN;
      anim_cnt   <= '0;
      phase      <= 1'b0;
      dead_cnt   <= '0;
      playerX    <= 10'(START_X);
      playerY    <= 10'(START_Y);
      sprite_num <= 3'd0;
      alive      <= 1'b1;
    end else if (state != DEAD && kill) begin
      state      <= DEAD;
      dead_cnt   <= '0;
      sprite_num <= 3'd6;
      alive      <= 1'b0;
    end else if (frame_tick) begin
      if (state == DEAD) begin
        if (dead_cnt == DEAD_LAST) begin
          state      <= IDLE;
          dir        <= DIR_DOWN;
          anim_cnt   <= '0;
          phase      <= 1'b0;
          dead_cnt   <= '0;
          playerX    <= 10'(START_X);
          playerY    <= 10'(START_Y);
          sprite_num <= 3'd0;
          alive      <= 1'b1;
        end else begin
          dead_cnt <= dead_cnt + 1'b1;
        end
      end else if (req_valid) begin
        state    <= WALK;
        dir      <= req_dir;
        playerX  <= new_x;
        playerY  <= new_y;
        anim_cnt <= anim_wrap ? '0 : anim_cnt + 1'b1;
        phase    <= next_phase;
        sprite_num <= next_phase ? {2'b10, req_dir[1]} : {1'b0, req_dir};
      end else begin
        state      <= IDLE;
        anim_cnt   <= '0;
        phase      <= 1'b0;
        sprite_num <= {1'b0, dir};
      end
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: a behavioural player model queues expected
// outputs per cycle; the DUT outputs are popped and compared after each edge.
module tb_player_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0, frame_tick = 1'b0, kill = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       blk_up = 1'b0, blk_down = 1'b0, blk_left = 1'b0, blk_right = 1'b0;
  logic [9:0] playerX, playerY;
  logic [2:0] sprite_num;
  logic       alive;

  player_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .blk_up(blk_up), .blk_down(blk_down), .blk_left(blk_left), .blk_right(blk_right),
    .kill(kill), .playerX(playerX), .playerY(playerY),
    .sprite_num(sprite_num), .alive(alive)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {int x; int y; int spr; int alv;} exp_t;
  exp_t sb[$];

  // Model state: st 0=idle 1=walk 2=dead
  int m_x = 32, m_y = 32, m_st = 0, m_dir = 0, m_cnt = 0, m_ph = 0, m_dc = 0;

  task automatic model_step(input bit rst, input bit tk, input bit [3:0] b,
                            input bit [3:0] k, input bit kl);
    int d;
    bit v;
    bit bl;
    exp_t e;
    if (rst) begin
      m_x = 32; m_y = 32; m_st = 0; m_dir = 0; m_cnt = 0; m_ph = 0; m_dc = 0;
    end else if (m_st != 2 && kl) begin
      m_st = 2; m_dc = 0;
    end else if (tk) begin
      if (m_st == 2) begin
        if (m_dc == 59) begin
          m_x = 32; m_y = 32; m_st = 0; m_dir = 0; m_cnt = 0; m_ph = 0; m_dc = 0;
        end else m_dc++;
      end else begin
        v = 1; d = 0; bl = 0;
        if (b[3])      begin d = 1; bl = k[3]; end
        else if (b[2]) begin d = 0; bl = k[2]; end
        else if (b[1]) begin d = 2; bl = k[1]; end
        else if (b[0]) begin d = 3; bl = k[0]; end
        else v = 0;
        if (v) begin
          m_st = 1; m_dir = d;
          if (!bl) begin
            case (d)
              0: m_y = (m_y + 2 > 416) ? 416 : m_y + 2;
              1: m_y = (m_y - 2 < 32) ? 32 : m_y - 2;
              2: m_x = (m_x - 2 < 32) ? 32 : m_x - 2;
              default: m_x = (m_x + 2 > 576) ? 576 : m_x + 2;
            endcase
          end
          if (m_cnt == 7) begin m_cnt = 0; m_ph = 1 - m_ph; end
          else m_cnt++;
        end else begin
          m_st = 0; m_cnt = 0; m_ph = 0;
        end
      end
    end
    e.x = m_x; e.y = m_y; e.alv = (m_st == 2) ? 0 : 1;
    if (m_st == 2) e.spr = 6;
    else if (m_st == 1 && m_ph == 1) e.spr = (m_dir < 2) ? 4 : 5;
    else e.spr = m_dir;
    sb.push_back(e);
  endtask

  // b/k bit order: {up, down, left, right}
  task automatic cyc(input bit rst, input bit tk, input bit [3:0] b,
                     input bit [3:0] k, input bit kl, input string tag);
    exp_t e;
    reset = rst; frame_tick = tk; kill = kl;
    {btn_up, btn_down, btn_left, btn_right} = b;
    {blk_up, blk_down, blk_left, blk_right} = k;
    model_step(rst, tk, b, k, kl);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_x"}, int'(playerX), e.x);
      check({tag, "_y"}, int'(playerY), e.y);
      check({tag, "_spr"}, int'(sprite_num), e.spr);
      check({tag, "_alive"}, int'(alive), e.alv);
    end
    reset = 1'b0; frame_tick = 1'b0; kill = 1'b0;
  endtask

  // One frame: tick cycle, then three cycles of random (ignored) joystick noise.
  task automatic frame(input bit [3:0] b, input bit [3:0] k, input bit kl,
                       input bit kill_between, input string tag);
    cyc(1'b0, 1'b1, b, k, kl, tag);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 4'($urandom), 4'($urandom), kill_between, {tag, "_hold"});
  endtask

  initial begin
    cyc(1'b1, 1'b0, 4'b0, 4'b0, 1'b0, "rst");
    cyc(1'b1, 1'b1, 4'b0001, 4'b0, 1'b1, "rst2");
    check("rst_x", int'(playerX), 32);
    check("rst_y", int'(playerY), 32);
    check("rst_spr", int'(sprite_num), 0);
    check("rst_alive", int'(alive), 1);

    // Walk right 16 ticks; explicit position and animation sequence.
    for (int t = 1; t <= 16; t++) begin
      frame(4'b0001, 4'b0, 1'b0, 1'b0, "right");
      if (t <= 3) check("right_x_const", int'(playerX), 32 + 2 * t);
      check("right_y_const", int'(playerY), 32);
      check("right_anim_const", int'(sprite_num), (t >= 8 && t <= 15) ? 5 : 3);
    end
    frame(4'b0000, 4'b0, 1'b0, 1'b0, "release");
    check("release_spr", int'(sprite_num), 3);

    // Left into the X_MIN clamp (X=64 -> 32 after 16, then stays).
    for (int t = 0; t < 18; t++) frame(4'b0010, 4'b0, 1'b0, 1'b0, "left");
    check("left_clamp", int'(playerX), 32);

    // Blocked up: position frozen, animation still runs.
    for (int t = 0; t < 10; t++) frame(4'b1000, 4'b1000, 1'b0, 1'b0, "upblk");
    check("upblk_y", int'(playerY), 32);

    // Down then up+left together: only Y moves.
    for (int t = 0; t < 5; t++) frame(4'b0100, 4'b0, 1'b0, 1'b0, "down");
    for (int t = 0; t < 3; t++) frame(4'b1010, 4'b0, 1'b0, 1'b0, "upleft");
    check("upleft_y", int'(playerY), 36);
    check("upleft_x", int'(playerX), 32);

    // Kill with a tick while walking, kill pulses while dead, respawn after 60 ticks.
    frame(4'b0001, 4'b0, 1'b0, 1'b0, "prekill");
    frame(4'b0001, 4'b0, 1'b1, 1'b1, "kill");
    check("kill_x_frozen", int'(playerX), 34);
    for (int t = 1; t <= 59; t++) frame(4'b0001, 4'b0, 1'b0, 1'b1, "dead");
    check("dead59_alive", int'(alive), 0);
    frame(4'b0001, 4'b0, 1'b0, 1'b0, "respawn");
    check("respawn_x", int'(playerX), 32);
    check("respawn_y", int'(playerY), 32);
    check("respawn_spr", int'(sprite_num), 0);
    check("respawn_alive", int'(alive), 1);

    // Reset at dead tick 30 together with tick and kill.
    frame(4'b0001, 4'b0, 1'b0, 1'b0, "walk2");
    frame(4'b0000, 4'b0, 1'b1, 1'b0, "kill2");
    for (int t = 1; t <= 29; t++) frame(4'b0000, 4'b0, 1'b0, 1'b0, "dead2");
    cyc(1'b1, 1'b1, 4'b0001, 4'b0, 1'b1, "dead_rst");
    check("dead_rst_alive", int'(alive), 1);
    check("dead_rst_x", int'(playerX), 32);
    frame(4'b0001, 4'b0, 1'b0, 1'b0, "after_rst");
    check("after_rst_x", int'(playerX), 34);

    // Random play.
    for (int t = 0; t < 300; t++)
      frame(4'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0), 1'b0, "rand");

    // Drive into the X_MAX clamp.
    cyc(1'b1, 1'b0, 4'b0, 4'b0, 1'b0, "rst3");
    for (int t = 0; t < 280; t++) frame(4'b0001, 4'b0, 1'b0, 1'b0, "rmax");
    check("right_clamp", int'(playerX), 576);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_ctrl.md
# player_ctrl

Per-player motion and animation controller. It turns joystick buttons and map-collision flags into the `playerX`, `playerY` and `sprite_num` values that the sprite renderer consumes. All updates happen once per video frame, so the position is stable during active display. One instance per player; the two instances differ only in their start-position parameters.

## Interface

Parameters:
- `START_X`, default 32: respawn/reset X in pixels.
- `START_Y`, default 32: respawn/reset Y in pixels.
- `SPEED`, default 2: pixels moved per frame while walking.
- `X_MIN` / `X_MAX`, defaults 32 / 576: inclusive X clamp range.
- `Y_MIN` / `Y_MAX`, defaults 32 / 416: inclusive Y clamp range.
- `ANIM_DIV`, default 8: frames per walk-animation phase (≥1).
- `DEAD_FRAMES`, default 60: frames spent dead before respawn (≥1).

Ports:
- `clk`  in  1: pixel clock, the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `frame_tick`  in  1: one-cycle pulse per frame, at the start of vertical blank.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each: joystick levels, active-high.
- `blk_up`, `blk_down`, `blk_left`, `blk_right`  in  1 each: a level from map collision meaning a move in that direction is forbidden this frame.
- `kill`  in  1: a one-cycle-or-longer pulse from the explosion logic.
- `playerX`  out  10: registered sprite top-left X.
- `playerY`  out  10: registered sprite top-left Y.
- `sprite_num`  out  3: registered sprite index, 0..6.
- `alive`  out  1: high except in DEAD.

## Operation

- The FSM has three states: IDLE, WALK and DEAD. It also holds a 2-bit `dir` register (0 = down, 1 = up, 2 = left, 3 = right), an animation counter with a `phase` bit, and a dead counter.
- Requested direction: only one direction is active per frame. When several buttons are held, priority is up > down > left > right. If no button is held, there is no request.
- On `frame_tick` in IDLE or WALK:
  - With a request: `dir` takes the requested direction and the state becomes WALK. The position moves by `SPEED` in that direction unless the matching `blk_*` is high. The move is computed at 11 bits signed and saturates to [MIN, MAX], so it never wraps.
  - A blocked request still updates `dir` and still animates, but the position does not change.
  - With no request: the state becomes IDLE, the animation counter clears to 0 and `phase` clears to 0.
- Animation:
  - In WALK, each `frame_tick` increments the counter.
  - When the counter reaches `ANIM_DIV-1`, the counter clears and `phase` toggles.
  - On an IDLE→WALK transition, the counter starts from 0 with `phase` = 0.
- `sprite_num`:
  - In IDLE, or in WALK with `phase` = 0, it equals `dir` (0..3).
  - In WALK with `phase` = 1, it is 4 for vertical directions and 5 for horizontal directions.
  - In DEAD it is 6.
- `kill`:
  - Sampled on every cycle, not only on ticks.
  - In IDLE or WALK, a `kill` sends the FSM to DEAD on the next edge and clears the dead counter.
  - `kill` beats a `frame_tick` in the same cycle: no move is applied.
  - `kill` is ignored while in DEAD.
- DEAD:
  - Position is frozen.
  - Each `frame_tick` increments the dead counter.
  - The tick on which the counter reaches `DEAD_FRAMES-1` respawns the player: position becomes (`START_X`, `START_Y`), `dir` becomes 0, the state becomes IDLE and the counters clear.
- Buttons and `blk_*` are ignored on cycles without `frame_tick`.

## Timing

- All outputs are registered.
- An update triggered by `frame_tick` in cycle N is visible on the outputs in cycle N+1.
- A `kill` in cycle N gives `alive` = 0 and `sprite_num` = 6 in cycle N+1.
- A respawn tick in cycle N gives the start position, `sprite_num` = 0 and `alive` = 1 in cycle N+1.
- Reset is synchronous and overrides everything, including a `frame_tick` or `kill` in the same cycle. The reset values are:
  - `playerX` = `START_X`, `playerY` = `START_Y`.
  - `sprite_num` = 0, `alive` = 1.
  - State IDLE, `dir` = 0, all counters and `phase` = 0.
- Reset asserted during DEAD returns the block directly to the reset values.
- Outputs change only on the cycle after a tick, a kill or a reset; they are constant for the rest of the frame.

## Test plan

1. Reset, then hold `btn_right` for 3 ticks with no blocks → `playerX` reads 34, 36, 38; `playerY` stays 32; `sprite_num` stays 3.
2. Hold `btn_right` for 16 ticks with default parameters → `sprite_num` is 3 for ticks 1–7, 5 for ticks 8–15 and 3 from tick 16. Release on the next tick → IDLE and `sprite_num` = 3.
3. From X = 33, hold `btn_left` for 2 ticks → X reads 32, then stays 32. Then hold `btn_up` with `blk_up` = 1 → Y unchanged, `sprite_num` goes to 1 and the walk animation still runs.
4. Press `btn_up` and `btn_left` together → only Y decreases by 2 per tick; `dir` = up.
5. Assert `kill` in the same cycle as a `frame_tick` while walking → no move is applied; the next cycle shows `alive` = 0 and `sprite_num` = 6. After 60 further ticks the next cycle shows (32, 32), `sprite_num` = 0 and `alive` = 1. Extra `kill` pulses while dead have no effect.
6. Assert `reset` at dead tick 30 together with a `frame_tick` → the next cycle shows the reset values; normal movement resumes on the following tick.
